regfile_write_arbiter: RTL and testbench

Two-client write-port arbiter for the 32-entry register file. Each client posts a single write into its own one-entry holding buffer with a valid/ready handshake. The arbiter drains the buffers round-robin onto the register file's single write port (wrenable, address, data), so that two producers (e.g. ALU writeback and load writeback) share one port without losing writes. Writes to address 0 are consumed but never issued, which keeps register zero at zero.

---
 rtl/regfile_write_arbiter.sv | 133 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Two clients share the register file's single write port. Each client has a
// one-entry holding buffer. Full buffers are drained round-robin onto a
// registered write port. Writes that target register 0 are consumed and never
// issued, so register zero always reads as zero.

module regfile_write_arbiter #(
   parameter int WIDTH = 32,
   parameter int ADDR  = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic [ADDR-1:0]  a_addr,
   input  logic [WIDTH-1:0] a_data,
   input  logic             b_valid,
   output logic             b_ready,
   input  logic [ADDR-1:0]  b_addr,
   input  logic [WIDTH-1:0] b_data,
   output logic             rf_wrenable,
   output logic [ADDR-1:0]  rf_addr,
   output logic [WIDTH-1:0] rf_data,
   output logic             zero_drop,
   output logic             busy
);

   localparam logic CLIENT_A = 1'b0;
   localparam logic CLIENT_B = 1'b1;

   // Holding buffers
   logic             a_full;
   logic [ADDR-1:0]  a_addr_q;
   logic [WIDTH-1:0] a_data_q;
   logic             b_full;
   logic [ADDR-1:0]  b_addr_q;
   logic [WIDTH-1:0] b_data_q;

   // Client that won the most recent grant
   logic             last_grant;

   // Arbitration results
   logic             grant_a;
   logic             grant_b;
   logic             grant_any;
   logic             grant_zero;
   logic [ADDR-1:0]  grant_addr;
   logic [WIDTH-1:0] grant_data;

   // Ready is pure registered state: no combinational path from valid.
   assign a_ready = ~a_full;
   assign b_ready = ~b_full;

   assign busy = a_full | b_full | rf_wrenable;

   // Round-robin pick between the full buffers; a tie goes to the client
   // that did not win last time.
   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      grant_a    = 1'b0;
      grant_b    = 1'b0;
      grant_addr = '0;
      grant_data = '0;
      if (a_full && b_full) begin
         grant_a = (last_grant == CLIENT_B);
         grant_b = (last_grant == CLIENT_A);
      end else begin
         grant_a = a_full;
         grant_b = b_full;
      end
      if (grant_a) begin
         grant_addr = a_addr_q;
         grant_data = a_data_q;
      end else if (grant_b) begin
         grant_addr = b_addr_q;
         grant_data = b_data_q;
      end
   end

   assign grant_any  = grant_a | grant_b;
   assign grant_zero = (grant_addr == '0);

   // Buffer occupancy: set on accept, cleared when drained. A buffer being
   // drained has ready low, so accept and drain never coincide.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         a_full <= 1'b0;
         b_full <= 1'b0;
      end else begin
         if (a_valid && a_ready) a_full <= 1'b1;
         else if (grant_a)       a_full <= 1'b0;
         if (b_valid && b_ready) b_full <= 1'b1;
         else if (grant_b)       b_full <= 1'b0;
      end
   end

   // Buffer payload capture on accept.
   always_ff @(posedge clk) begin
      // NOTE: payload has no reset; it is only looked at while the full bit is set.
      if (a_valid && a_ready) begin
         a_addr_q <= a_addr;
         a_data_q <= a_data;
      end
      if (b_valid && b_ready) begin
         b_addr_q <= b_addr;
         b_data_q <= b_data;
      end
   end

   // Registered write port, zero-drop pulse and round-robin history.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rf_wrenable <= 1'b0;
         rf_addr     <= '0;
         rf_data     <= '0;
         zero_drop   <= 1'b0;
         last_grant  <= CLIENT_B;
      end else begin
         rf_wrenable <= grant_any & ~grant_zero;
         zero_drop   <= grant_any &  grant_zero;
         if (grant_any) begin
            last_grant <= grant_b ? CLIENT_B : CLIENT_A;
         end
         // Address and data hold their last issued value otherwise.
         if (grant_any && !grant_zero) begin
            rf_addr <= grant_addr;
            rf_data <= grant_data;
         end
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, single write, ties and
// round-robin order, address-0 drop, same-address collision and saturation
// with a per-client scoreboard.

module tb_regfile_write_arbiter;

   logic        clk;
   logic        reset_n;
   logic        a_valid;
   logic        a_ready;
   logic [4:0]  a_addr;
   logic [31:0] a_data;
   logic        b_valid;
   logic        b_ready;
   logic [4:0]  b_addr;
   logic [31:0] b_data;
   logic        rf_wrenable;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data;
   logic        zero_drop;
   logic        busy;

   int checks = 0;
   int errors = 0;

   // Saturation scoreboard: {addr, data} per client in acceptance order
   logic [36:0] qa[$];
   logic [36:0] qb[$];
   int          issued = 0;
   int          accepted = 0;
   logic        prev_client;
   logic        have_prev = 1'b0;

   regfile_write_arbiter #(.WIDTH(32), .ADDR(5)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .a_valid     (a_valid),
      .a_ready     (a_ready),
      .a_addr      (a_addr),
      .a_data      (a_data),
      .b_valid     (b_valid),
      .b_ready     (b_ready),
      .b_addr      (b_addr),
      .b_data      (b_data),
      .rf_wrenable (rf_wrenable),
      .rf_addr     (rf_addr),
      .rf_data     (rf_data),
      .zero_drop   (zero_drop),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Advance to 1 time unit past the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic post_a(input logic [4:0] addr, input logic [31:0] data);
      a_valid = 1'b1;
      a_addr  = addr;
      a_data  = data;
   endtask

   task automatic post_b(input logic [4:0] addr, input logic [31:0] data);
      b_valid = 1'b1;
      b_addr  = addr;
      b_data  = data;
   endtask

   // Compare one issued write against the scoreboard of the client that owns
   // the address range (A: 16..23, B: 24..31).
   task automatic score_issue();
      logic [36:0] ent;
      logic        client;
      if (rf_wrenable) begin
         issued++;
         client = rf_addr[3];
         if (have_prev) check("sat_alternate", {31'd0, client}, {31'd0, ~prev_client});
         prev_client = client;
         have_prev   = 1'b1;
         if (client) begin
            check("sat_b_pending", (qb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (qb.size() > 0) begin
               ent = qb.pop_front();
               check("sat_b_addr", {27'd0, rf_addr}, {27'd0, ent[36:32]});
               check("sat_b_data", rf_data, ent[31:0]);
            end
         end else begin
            check("sat_a_pending", (qa.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (qa.size() > 0) begin
               ent = qa.pop_front();
               check("sat_a_addr", {27'd0, rf_addr}, {27'd0, ent[36:32]});
               check("sat_a_data", rf_data, ent[31:0]);
            end
         end
      end
   endtask

   initial begin
      logic acc_a;
      logic acc_b;
      int   ka;
      int   kb;

      reset_n = 1'b0;
      a_valid = 1'b0;
      a_addr  = '0;
      a_data  = '0;
      b_valid = 1'b0;
      b_addr  = '0;
      b_data  = '0;

      // Reset state, before any clock edge
      #1;
      check("rst_a_ready", {31'd0, a_ready}, 32'd1);
      check("rst_b_ready", {31'd0, b_ready}, 32'd1);
      check("rst_we", {31'd0, rf_wrenable}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_zero_drop", {31'd0, zero_drop}, 32'd0);
      tick();
      tick();
      reset_n = 1'b1;
      tick();

      // Reset mid-operation: A issuing, B still buffered
      post_a(5'd9, 32'h0000_0099);
      post_b(5'd10, 32'h0000_00AA);
      tick();
      a_valid = 1'b0;
      b_valid = 1'b0;
      tick();
      check("pre_rst_we", {31'd0, rf_wrenable}, 32'd1);
      check("pre_rst_addr", {27'd0, rf_addr}, 32'd9);
      check("pre_rst_b_ready", {31'd0, b_ready}, 32'd0);
      #3;
      reset_n = 1'b0;
      #1;
      check("mid_rst_we", {31'd0, rf_wrenable}, 32'd0);
      check("mid_rst_b_ready", {31'd0, b_ready}, 32'd1);
      check("mid_rst_addr", {27'd0, rf_addr}, 32'd0);
      check("mid_rst_data", rf_data, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      tick();
      #2;
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("post_rst_we", {31'd0, rf_wrenable}, 32'd0);
         check("post_rst_zd", {31'd0, zero_drop}, 32'd0);
      end

      // Tie after reset: A first, then B
      post_a(5'd1, 32'h11);
      post_b(5'd2, 32'h22);
      tick();
      a_valid = 1'b0;
      b_valid = 1'b0;
      check("tie1_a_ready_e0", {31'd0, a_ready}, 32'd0);
      check("tie1_b_ready_e0", {31'd0, b_ready}, 32'd0);
      check("tie1_we_e0", {31'd0, rf_wrenable}, 32'd0);
      tick();
      check("tie1_we_e1", {31'd0, rf_wrenable}, 32'd1);
      check("tie1_addr_e1", {27'd0, rf_addr}, 32'd1);
      check("tie1_data_e1", rf_data, 32'h11);
      check("tie1_a_ready_e1", {31'd0, a_ready}, 32'd1);
      check("tie1_b_ready_e1", {31'd0, b_ready}, 32'd0);
      tick();
      check("tie1_we_e2", {31'd0, rf_wrenable}, 32'd1);
      check("tie1_addr_e2", {27'd0, rf_addr}, 32'd2);
      check("tie1_data_e2", rf_data, 32'h22);
      check("tie1_b_ready_e2", {31'd0, b_ready}, 32'd1);
      tick();
      check("tie1_we_e3", {31'd0, rf_wrenable}, 32'd0);
      check("tie1_busy_e3", {31'd0, busy}, 32'd0);

      // Second tie: B won last, so A goes first again
      post_a(5'd3, 32'h33);
      post_b(5'd4, 32'h44);
      tick();
      a_valid = 1'b0;
      b_valid = 1'b0;
      tick();
      check("tie2_addr_e1", {27'd0, rf_addr}, 32'd3);
      check("tie2_data_e1", rf_data, 32'h33);
      tick();
      check("tie2_addr_e2", {27'd0, rf_addr}, 32'd4);
      check("tie2_data_e2", rf_data, 32'h44);
      tick();

      // Address-0 write from B is dropped
      post_b(5'd0, 32'hFFFF_FFFF);
      tick();
      b_valid = 1'b0;
      check("zero_b_ready_e0", {31'd0, b_ready}, 32'd0);
      tick();
      check("zero_we_e1", {31'd0, rf_wrenable}, 32'd0);
      check("zero_pulse_e1", {31'd0, zero_drop}, 32'd1);
      check("zero_b_ready_e1", {31'd0, b_ready}, 32'd1);
      check("zero_addr_hold", {27'd0, rf_addr}, 32'd4);
      check("zero_data_hold", rf_data, 32'h44);
      tick();
      check("zero_pulse_e2", {31'd0, zero_drop}, 32'd0);
      check("zero_we_e2", {31'd0, rf_wrenable}, 32'd0);
      check("zero_busy_e2", {31'd0, busy}, 32'd0);

      // Single uncontended write
      post_a(5'd5, 32'hDEAD_BEEF);
      tick();
      a_valid = 1'b0;
      check("single_a_ready_e0", {31'd0, a_ready}, 32'd0);
      check("single_we_e0", {31'd0, rf_wrenable}, 32'd0);
      check("single_busy_e0", {31'd0, busy}, 32'd1);
      tick();
      check("single_we_e1", {31'd0, rf_wrenable}, 32'd1);
      check("single_addr_e1", {27'd0, rf_addr}, 32'd5);
      check("single_data_e1", rf_data, 32'hDEAD_BEEF);
      check("single_a_ready_e1", {31'd0, a_ready}, 32'd1);
      tick();
      check("single_we_e2", {31'd0, rf_wrenable}, 32'd0);

      // Same-address collision with last_grant = A: B issues first
      post_a(5'd7, 32'h1);
      post_b(5'd7, 32'h2);
      tick();
      a_valid = 1'b0;
      b_valid = 1'b0;
      tick();
      check("coll_we_e1", {31'd0, rf_wrenable}, 32'd1);
      check("coll_addr_e1", {27'd0, rf_addr}, 32'd7);
      check("coll_data_e1", rf_data, 32'h2);
      tick();
      check("coll_we_e2", {31'd0, rf_wrenable}, 32'd1);
      check("coll_data_e2", rf_data, 32'h1);
      tick();
      check("coll_we_e3", {31'd0, rf_wrenable}, 32'd0);
      check("coll_final_data", rf_data, 32'h1);

      // Saturation: both clients keep valid high
      ka = 0;
      kb = 0;
      post_a(5'd16, 32'hA000_0000);
      post_b(5'd24, 32'hB000_0000);
      for (int i = 0; i < 20; i++) begin
         acc_a = a_ready;
         acc_b = b_ready;
         tick();
         if (acc_a) begin
            qa.push_back({a_addr, a_data});
            accepted++;
            ka++;
            a_addr = 5'(16 + (ka % 8));
            a_data = 32'hA000_0000 + 32'(ka);
         end
         if (acc_b) begin
            qb.push_back({b_addr, b_data});
            accepted++;
            kb++;
            b_addr = 5'(24 + (kb % 8));
            b_data = 32'hB000_0000 + 32'(kb);
         end
         if (i >= 1) check("sat_we_every_cycle", {31'd0, rf_wrenable}, 32'd1);
         score_issue();
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         score_issue();
      end
      check("sat_qa_empty", qa.size(), 32'd0);
      check("sat_qb_empty", qb.size(), 32'd0);
      check("sat_issued", issued, accepted);
      check("sat_accepted_min", (accepted >= 18) ? 32'd1 : 32'd0, 32'd1);
      check("sat_idle_busy", {31'd0, busy}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #100000;
      $display("FAIL timeout observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
